// File: rtl/alu_mc.sv
// Multi-cycle unsigned ALU with start/busy/done handshake and a shift-add multiplier.
// Define ALU_MAC_EN to build the accumulator with the MAC and CLRACC opcodes.
module alu_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MULT = 1'b1;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_INC  = 3'd6;
`ifdef ALU_MAC_EN
    localparam logic [2:0] OP_MAC    = 3'd4;
    localparam logic [2:0] OP_CLRACC = 3'd5;
`endif

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [0:0]         state;
    logic [2:0]         op_q;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               is_mult;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_ovf;

`ifdef ALU_MAC_EN
    logic [WIDTH-1:0]   acc;
    logic [WIDTH:0]     acc_sum;
    assign is_mult = (alu_op == OP_MUL) || (alu_op == OP_MAC);
`else
    assign is_mult = (alu_op == OP_MUL);
`endif

    assign busy = (state == MULT);

    // Results of the ops that complete in the accepting cycle; MUL/MAC codes never reach here.
    always_comb begin
        sum_ext = '0;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        case (alu_op)
            OP_PASS: sc_res = in1;
            OP_ADD: begin
                sum_ext = {1'b0, in1} + {1'b0, in2};
                sc_res  = sum_ext[WIDTH-1:0];
                sc_ovf  = sum_ext[WIDTH];
            end
            OP_SUB: begin
                sum_ext = {1'b0, in1} - {1'b0, in2};
                sc_res  = sum_ext[WIDTH-1:0];
                sc_ovf  = sum_ext[WIDTH];
            end
            OP_INC: begin
                sum_ext = {1'b0, in1} + (WIDTH+1)'(1);
                sc_res  = sum_ext[WIDTH-1:0];
                sc_ovf  = sum_ext[WIDTH];
            end
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // The last iteration's partial sum is used directly so the result lands on edge WIDTH.
    always_comb begin
        prod_next = mplier[0] ? (prod + mcand) : prod;
        fin_res   = prod_next[WIDTH-1:0];
        fin_ovf   = |prod_next[2*WIDTH-1:WIDTH];
`ifdef ALU_MAC_EN
        acc_sum   = {1'b0, acc} + {1'b0, prod_next[WIDTH-1:0]};
        if (op_q == OP_MAC) begin
            fin_res = acc_sum[WIDTH-1:0];
            fin_ovf = (|prod_next[2*WIDTH-1:WIDTH]) | acc_sum[WIDTH];
        end
`else
        if (op_q != OP_MUL) begin
            fin_res = '0;
            fin_ovf = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_PASS;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            count   <= '0;
            alu_out <= '0;
            z       <= 1'b1;
            ovf     <= 1'b0;
            done    <= 1'b0;
`ifdef ALU_MAC_EN
            acc     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && is_mult) begin
                    op_q   <= alu_op;
                    mcand  <= {{WIDTH{1'b0}}, in1};
                    mplier <= in2;
                    prod   <= '0;
                    count  <= '0;
                    state  <= MULT;
                end else if (start) begin
                    alu_out <= sc_res;
                    z       <= (sc_res == '0);
                    ovf     <= sc_ovf;
                    done    <= 1'b1;
`ifdef ALU_MAC_EN
                    if (alu_op == OP_CLRACC) begin
                        acc <= '0;
                    end
`endif
                end
            end else begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (count == LAST) begin
                    alu_out <= fin_res;
                    z       <= (fin_res == '0);
                    ovf     <= fin_ovf;
                    done    <= 1'b1;
                    state   <= IDLE;
`ifdef ALU_MAC_EN
                    if (op_q == OP_MAC) begin
                        acc <= fin_res;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16; covers the ALU_MAC_EN build when defined.
module tb_alu_mc;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  alu_op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [15:0] alu_out;
    logic        z;
    logic        ovf;
    logic        busy;
    logic        done;

    int total;
    int bad;

    alu_mc #(.WIDTH(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .alu_op  (alu_op),
        .in1     (in1),
        .in2     (in2),
        .alu_out (alu_out),
        .z       (z),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one op for exactly one rising edge; returns just after that edge (edge 0).
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        start  = 1'b1;
        alu_op = op;
        in1    = a;
        in2    = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Latency counts cycles after edge 0; the bound keeps a stuck DUT from hanging the run.
    task automatic waitDone(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic runVector(input string tag, input logic [2:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp_out,
                             input logic exp_ovf, input int exp_lat);
        int lat;
        int bc;
        applyStimulus(op, a, b);
        waitDone(lat, bc);
        checkOutput({tag, "_out"}, 32'(alu_out), 32'(exp_out));
        checkOutput({tag, "_z"}, 32'(z), 32'(exp_out == 16'h0));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busycyc"}, 32'(bc), 32'(exp_lat - 1));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int dones;
        logic [15:0] last;

        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        start  = 1'b0;
        alu_op = 3'd0;
        in1    = 16'h0;
        in2    = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_out", 32'(alu_out), 32'h0);
        checkOutput("rst_z", 32'(z), 32'd1);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        runVector("add", 3'd1, 16'd3, 16'd6, 16'd9, 1'b0, 1);
        // With no new start the result must hold and done must drop.
        @(posedge clock);
        #1;
        checkOutput("hold_done", 32'(done), 32'd0);
        checkOutput("hold_out", 32'(alu_out), 32'd9);

        runVector("sub", 3'd2, 16'd7, 16'd10, 16'hFFFD, 1'b1, 1);
        runVector("pass0", 3'd0, 16'd0, 16'd5, 16'h0000, 1'b0, 1);
        runVector("addc", 3'd1, 16'hFFFF, 16'd2, 16'h0001, 1'b1, 1);
        runVector("inc", 3'd6, 16'hFFFF, 16'd0, 16'h0000, 1'b1, 1);
        runVector("rsv7", 3'd7, 16'd9, 16'd9, 16'h0000, 1'b0, 1);

        // Consecutive-edge single-cycle ops each produce their own done.
        applyStimulus(3'd1, 16'd10, 16'd20);
        checkOutput("b2b1_done", 32'(done), 32'd1);
        checkOutput("b2b1_out", 32'(alu_out), 32'd30);
        applyStimulus(3'd6, 16'd41, 16'd0);
        checkOutput("b2b2_done", 32'(done), 32'd1);
        checkOutput("b2b2_out", 32'(alu_out), 32'd42);

        runVector("mul255", 3'd3, 16'd255, 16'd255, 16'hFE01, 1'b0, 17);

        // Operands dropped to zero right after acceptance must not affect the product.
        applyStimulus(3'd3, 16'd300, 16'd300);
        in1 = 16'h0;
        in2 = 16'h0;
        waitDone(lat, bc);
        checkOutput("mul300_out", 32'(alu_out), 32'h5F90);
        checkOutput("mul300_ovf", 32'(ovf), 32'd1);
        checkOutput("mul300_lat", 32'(lat), 32'd17);

`ifdef ALU_MAC_EN
        runVector("clracc", 3'd5, 16'd7, 16'd7, 16'h0000, 1'b0, 1);
        runVector("mac1", 3'd4, 16'd2, 16'd3, 16'd6, 1'b0, 17);
        runVector("mac2", 3'd4, 16'd4, 16'd5, 16'd26, 1'b0, 17);
        runVector("mac3", 3'd4, 16'hFFFF, 16'd1, 16'h0019, 1'b1, 17);
        runVector("mul_after_mac", 3'd3, 16'd3, 16'd4, 16'd12, 1'b0, 17);
`else
        runVector("mac_rsv", 3'd4, 16'd5, 16'd5, 16'h0000, 1'b0, 1);
        runVector("clr_rsv", 3'd5, 16'd5, 16'd5, 16'h0000, 1'b0, 1);
`endif

        // A start pulse mid-multiply is ignored: one done, multiply result only.
        applyStimulus(3'd3, 16'd255, 16'd255);
        dones = 0;
        last  = 16'h0;
        for (int i = 1; i < 25; i++) begin
            @(negedge clock);
            start  = (i == 4);
            alu_op = 3'd1;
            in1    = 16'd1;
            in2    = 16'd1;
            @(posedge clock);
            #1;
            if (done) begin
                dones++;
                last = alu_out;
            end
        end
        start = 1'b0;
        checkOutput("ign_dones", 32'(dones), 32'd1);
        checkOutput("ign_out", 32'(last), 32'hFE01);

        // Reset during iteration 8 discards the multiply.
        applyStimulus(3'd3, 16'd300, 16'd300);
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midrst_out", 32'(alu_out), 32'h0);
        checkOutput("midrst_z", 32'(z), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (done || busy) dones++;
        end
        checkOutput("midrst_quiet", 32'(dones), 32'd0);
        runVector("post_rst_add", 3'd1, 16'd1, 16'd1, 16'd2, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
